cs_frame_shifter: RTL
=====================

# cs_frame_shifter

Consumes the registered chip-select level (`cs1`) and the one-cycle edge strobe (`cs2`) produced by the chip-select conversion stage and turns them into a serial bit stream. A parallel word is accepted from the upstream data source over a valid/ready handshake. While `cs1` is high, each `cs2` strobe advances one bit on `sdo`. The block reports completion, or abort if `cs1` drops mid-frame, with single-cycle pulses.

## Interface
Parameters:
- `WIDTH`, 8, bits per frame (2..32)
- `MSB_FIRST`, 1, 1 = shift MSB first, 0 = LSB first

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `cs1`  in  1  frame-enable level from chip-select stage
- `cs2`  in  1  one-cycle bit strobe from chip-select stage
- `din`  in  WIDTH  word to transmit
- `din_valid`  in  1  `din` valid
- `din_ready`  out  1  block can accept a word
- `sdo`  out  1  serial data out, registered
- `busy`  out  1  high in ARMED, SHIFT, DONE
- `bit_cnt`  out  $clog2(WIDTH+1)  bits already shifted in current frame
- `frame_done`  out  1  one-cycle pulse, frame completed
- `frame_abort`  out  1  one-cycle pulse, `cs1` fell before completion

## Operation
- States: IDLE, ARMED, SHIFT, DONE.
- IDLE: `din_ready`=1. On `din_valid & din_ready`, capture `din` into the shift register, go to ARMED. `cs1`/`cs2` are ignored.
- ARMED: wait for `cs1`=1, then go to SHIFT. `sdo` takes the first bit (`din[WIDTH-1]` if MSB_FIRST, else `din[0]`). `cs2` is ignored.
- SHIFT, `cs1`=1 and `cs2`=1: shift one position and increment `bit_cnt`. `sdo` takes the next bit. If `bit_cnt`==WIDTH-1 before the increment, go to DONE (`bit_cnt` becomes WIDTH).
- SHIFT, `cs1`=0: go to IDLE. Pulse `frame_abort`. Discard the word. Clear `bit_cnt` and `sdo`. Abort wins over a simultaneous `cs2`.
- DONE: pulse `frame_done` for this one cycle, then go to IDLE. Clear `bit_cnt`, and `sdo` becomes 0. `cs1`/`cs2` are ignored.
- `din_ready` is decoded from state (IDLE only). `din_valid` outside IDLE is ignored; it has no queueing.
- Shift-register vacated bits fill with 0.

## Timing
- Reset values, at the first posedge with `rst`=1: state IDLE, `sdo`=0, `busy`=0, `bit_cnt`=0, `frame_done`=0, `frame_abort`=0, shift register 0. `din_ready`=1 from the cycle after the reset edge.
- `rst` high in any state returns the block to IDLE on that edge; an in-flight frame is dropped with no abort pulse.
- Accept to ARMED: 1 cycle. ARMED to SHIFT: 1 cycle after `cs1` is sampled high. If `cs1` is already high at accept, SHIFT is entered 2 cycles after the accept edge.
- Each `cs2` strobe updates `sdo`/`bit_cnt` at the same edge it is sampled.
- `frame_done` is high the cycle after the WIDTH-th strobe. `din_ready` returns 1 the cycle after that, so the minimum accept-to-accept interval is WIDTH + 4 cycles with back-to-back strobes.
- Back-to-back `cs2` on consecutive cycles is legal.

## Structure
- Shared package `cs_pkg`: state enum `cs_state_t` {IDLE, ARMED, SHIFT, DONE} and a `CS_MAX_WIDTH`=32 constant. The conversion stage uses the same package.
- One sub-module, `frame_shreg`: WIDTH-bit loadable shift register. Ports: load, shift, din, and serial out, with MSB_FIRST passed through. The FSM, counter and pulses live in the top.

## Test plan
- Reset: assert `rst` mid-SHIFT at `bit_cnt`=3 -> next cycle IDLE, `sdo`=0, `bit_cnt`=0, no `frame_abort`, `din_ready`=1.
- Nominal MSB-first, WIDTH=8: load 0xA5, raise `cs1`, 8 strobes spaced 3 cycles -> `sdo` sequence 1,0,1,0,0,1,0,1. `frame_done` pulses once, `bit_cnt` reads 8 in DONE.
- LSB-first, WIDTH=8: load 0x01, back-to-back strobes -> `sdo` 1 then 0×7. `frame_done` 1 cycle after the 8th strobe.
- Abort: load 0xFF, 4 strobes, drop `cs1` on the same cycle as a 5th strobe -> `frame_abort` pulse, `bit_cnt` 0, no `frame_done`, `din_ready`=1.
- Ignored inputs: `cs2` strobes in IDLE/ARMED and `din_valid` in SHIFT -> `bit_cnt` unchanged, captured word unchanged.
- Back-to-back frames: `din_valid` held high with 0x3C then 0xC3, `cs1` high -> two `frame_done` pulses, correct bit streams, accept-to-accept interval of 12 cycles.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the chip-select conversion and frame shifting stages.
//   cs_state_t   : frame FSM states
//   CS_MAX_WIDTH : largest supported frame width
package cs_pkg;

  localparam int unsigned CS_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cs_state_t;

endpackage

// File: rtl/frame_shreg.sv
// Loadable WIDTH-bit shift register with zero fill.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : advance one position toward the serial end
//   din      : parallel word
//   sout     : current head bit (MSB or LSB depending on MSB_FIRST)
module frame_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/cs_frame_shifter.sv
// Serialises a parallel word under control of the chip-select level (cs1)
// and bit strobe (cs2).
//   clk, rst     : clock, synchronous active-high reset
//   cs1, cs2     : frame-enable level, one-cycle bit strobe
//   din          : word to transmit, with din_valid/din_ready handshake
//   sdo          : registered serial data
//   busy         : frame in progress (ARMED, SHIFT, DONE)
//   bit_cnt      : bits shifted so far in the current frame
//   frame_done   : one-cycle pulse on completion
//   frame_abort  : one-cycle pulse when cs1 drops mid-frame
module cs_frame_shifter
  import cs_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs1,
  input  logic                       cs2,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       sdo,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       frame_done,
  output logic                       frame_abort
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  cs_state_t        state;
  logic             go;       // cs1 seen high on the previous ARMED edge
  logic             sout;
  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] sh_din_c;

  // Load on accept; on abort load zeros so the dropped word does not linger.
  assign load_c   = ((state == IDLE) && din_valid) || ((state == SHIFT) && !cs1);
  assign sh_din_c = (state == IDLE) ? din : '0;
  // The head bit is moved into sdo on SHIFT entry and on every strobe,
  // so the register advances at exactly those edges.
  assign shift_c  = ((state == ARMED) && go && cs1) ||
                    ((state == SHIFT) && cs1 && cs2);

  assign din_ready = (state == IDLE);

  frame_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load_c),
    .shift (shift_c),
    .din   (sh_din_c),
    .sout  (sout)
  );

  // Frame FSM, bit counter and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      go          <= 1'b0;
      sdo         <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            state <= ARMED;
            busy  <= 1'b1;
            go    <= 1'b0;
          end
        end
        ARMED: begin
          go <= cs1;
          if (go && cs1) begin
            state <= SHIFT;
            sdo   <= sout;
            go    <= 1'b0;
          end
        end
        SHIFT: begin
          if (!cs1) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            sdo         <= 1'b0;
            frame_abort <= 1'b1;
          end else if (cs2) begin
            sdo     <= sout;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH - 1)) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
          sdo     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
